srv_mem_fill: RTL and testbench
===============================

Name: srv_mem_fill

Overview:
Parametrised line-fill memory controller between the instruction cache refill port and the instruction ROM. It replaces the fixed 4-word, zero-latency fill path with a configurable one. Line size, ROM read latency and fill order (linear or critical-word-first wrap) are all parameters. It issues one ROM word read per cycle, places each word in its line slot, and returns the whole line with a single-cycle response pulse. A saturating fill counter is provided for debug.

Parameters:
WORDS, 4, 32-bit words per line; power of 2, 1..16; line is WORDS*4 bytes.
ROM_LAT, 0, ROM read latency in cycles, 0..3; 0 = combinational ROM.
WRAP_EN, 0, 1 = fetch critical word first, then wrap within the line; 0 = linear from line base.
CNT_W, 16, width of the fill counter.

Ports:
clk  in  1  system clock; single clock domain.
rst_n  in  1  asynchronous active-low reset.
ext_addr_i  in  32  requested byte address; any alignment; sampled only on acceptance.
ext_req_i  in  1  fill request; level, held by the cache until ext_rsp_o.
ext_rsp_o  out  1  one-cycle pulse: line in ext_data_o is valid.
ext_data_o  out  WORDS*32  filled line; word k at bits [32k+31:32k].
rom_addr_o  out  32  byte address of the ROM word being read; always word-aligned.
rom_data_i  in  32  ROM data, valid ROM_LAT cycles after rom_addr_o.
busy_o  out  1  high in FILL and RESP.
fill_cnt_o  out  CNT_W  number of completed fills; saturates at all-ones.

Behaviour:
- Reset values (asynchronous, immediate): state IDLE; ext_rsp_o=0; ext_data_o=0; rom_addr_o=0; busy_o=0; fill_cnt_o=0; issue/capture counters and latency pipeline valids cleared.
- Address arithmetic:
  - base = ext_addr_i with the low log2(WORDS*4) bits cleared.
  - crit = ext_addr_i[log2(WORDS*4)-1:2] when WRAP_EN=1, else 0.
  - The k-th issued word index is (crit+k) mod WORDS, computed in log2(WORDS) bits so it wraps naturally.
  - rom_addr_o = base + 4*index.
  - When WORDS=1, index is constant 0.
- FSM states IDLE, FILL, RESP.
  - IDLE: when ext_req_i=1 at a clock edge, register base and crit, then go to FILL. Call the cycle with ext_req_i high in IDLE cycle 0.
  - FILL: issue one address per cycle. Word k is issued in cycle 1+k, k=0..WORDS-1.
  - FILL capture: a ROM_LAT-deep pipeline carries (valid, index) alongside each issue. Data is captured into ext_data_o slot[index] at the end of cycle 1+k+ROM_LAT. ROM_LAT=0 captures in the issue cycle.
  - FILL exit: after the last capture (end of cycle WORDS+ROM_LAT), go to RESP. Issue stops after WORDS words; rom_addr_o holds the last issued address.
  - RESP: ext_rsp_o=1 for exactly cycle WORDS+ROM_LAT+1; fill_cnt_o increments at the end of RESP unless all-ones. Then go to IDLE.
  - RESP ignores ext_req_i. The earliest next acceptance is the first IDLE cycle, so back-to-back fills have a one-cycle gap.
- Outputs are registered. ext_data_o is stable from RESP until the first capture of the next fill. Slots are overwritten individually during the next fill and are not cleared between fills.
- ext_addr_i and ext_req_i changes during FILL/RESP are ignored; the registered address is used.
- ext_req_i dropping mid-fill does not abort the fill; the response pulse is still produced.
- Reset asserted mid-fill: everything returns to reset values at once, no response pulse is generated, and partial data is discarded (ext_data_o=0).
- ROM_LAT>0 with WORDS=1: rsp in cycle 2+ROM_LAT.

Test Plan:
1. WORDS=4, ROM_LAT=0, WRAP_EN=0, ROM returns data=address; ext_req_i with addr 0x24 -> rom_addr_o 0x20,0x24,0x28,0x2C in cycles 1..4; ext_rsp_o high only in cycle 5; ext_data_o=0x0000002C_00000028_00000024_00000020; fill_cnt_o=1.
2. Same with WRAP_EN=1, addr 0x28 -> rom_addr_o 0x28,0x2C,0x20,0x24; ext_data_o identical slot order (0x2C,0x28,0x24,0x20 high to low); rsp in cycle 5.
3. ROM_LAT=2, WORDS=8, addr 0x104 -> rom_addr_o 0x100..0x11C in cycles 1..8; rsp in cycle 11; slot 7 = 0x11C.
4. ext_req_i held high continuously, addrs 0x00 then 0x40 -> first rsp cycle 5, second acceptance cycle 6, second rsp cycle 11; ext_addr_i change during FILL has no effect.
5. rst_n low in cycle 3 of a fill -> ext_rsp_o never pulses, ext_data_o=0, busy_o=0 immediately; next request after reset completes normally.
6. CNT_W=2, five fills -> fill_cnt_o 1,2,3,3,3 (saturates).

Source files
------------

// File: rtl/srv_mem_fill.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : srv_mem_fill
// Purpose  : Line-fill controller between the I-cache refill port and the
//            instruction ROM. Reads one ROM word per cycle (linear or
//            critical-word-first wrap), places each word in its line slot,
//            and returns the whole line with a one-cycle response pulse.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            ext_addr_i/ext_req_i - refill request (byte address, level req)
//            ext_rsp_o/ext_data_o - line-valid pulse and filled line
//            rom_addr_o/rom_data_i- ROM word address out, data in (ROM_LAT)
//            busy_o               - high while filling or responding
//            fill_cnt_o           - saturating count of completed fills
// Revision : 1.0 - initial release
// ============================================================================
module srv_mem_fill #(
  parameter int WORDS   = 4,
  parameter int ROM_LAT = 0,
  parameter int WRAP_EN = 0,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          ext_addr_i,
  input  logic                 ext_req_i,
  output logic                 ext_rsp_o,
  output logic [WORDS*32-1:0]  ext_data_o,
  output logic [31:0]          rom_addr_o,
  input  logic [31:0]          rom_data_i,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     fill_cnt_o
);

  localparam int OFF_W = $clog2(WORDS*4);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_K = $clog2(WORDS+1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0]      base_q;
  logic [IDX_W-1:0] issue_idx;   // slot index currently on rom_addr_o
  logic [CNT_K-1:0] issued;      // words issued so far in this fill
  logic [CNT_K-1:0] captured;    // words captured so far in this fill
  logic             issuing;
  logic             cap_v;
  logic [IDX_W-1:0] cap_idx;
  logic             last_cap;
  logic [31:0]      base_in;
  logic [IDX_W-1:0] crit_in;
  logic             unused_addr;

  // Low address bits only matter through base/crit; fold them so every bit
  // of the request address is consumed for any parameter set.
  assign unused_addr = ^ext_addr_i;

  assign base_in = {ext_addr_i[31:OFF_W], {OFF_W{1'b0}}};

  if (WRAP_EN != 0 && WORDS > 1) begin : g_crit_wrap
    assign crit_in = ext_addr_i[OFF_W-1:2];
  end else begin : g_crit_lin
    assign crit_in = '0;
  end

  function automatic logic [31:0] word_addr(input logic [31:0]      b,
                                            input logic [IDX_W-1:0] i);
    return b + {{(30-IDX_W){1'b0}}, i, 2'b00};
  endfunction

  assign issuing  = (state == FILL) && (issued < CNT_K'(WORDS));
  assign last_cap = cap_v && (captured == CNT_K'(WORDS-1));

  // Latency pipeline: each issued index travels ROM_LAT stages so the
  // capture lands on the cycle its ROM data is valid.
  if (ROM_LAT == 0) begin : g_lat0
    assign cap_v   = issuing;
    assign cap_idx = issue_idx;
  end else begin : g_latn
    logic [ROM_LAT-1:0] pv;
    logic [IDX_W-1:0]   pidx [ROM_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv <= '0;
        for (int i = 0; i < ROM_LAT; i++) pidx[i] <= '0;
      end else begin
        pv[0]   <= issuing;
        pidx[0] <= issue_idx;
        for (int i = 1; i < ROM_LAT; i++) begin
          pv[i]   <= pv[i-1];
          pidx[i] <= pidx[i-1];
        end
      end
    end

    assign cap_v   = pv[ROM_LAT-1];
    assign cap_idx = pidx[ROM_LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ext_req_i) state_nxt = FILL;
      FILL:    if (last_cap)  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      issue_idx  <= '0;
      issued     <= '0;
      captured   <= '0;
      rom_addr_o <= '0;
      ext_data_o <= '0;
      ext_rsp_o  <= 1'b0;
      busy_o     <= 1'b0;
      fill_cnt_o <= '0;
    end else begin
      ext_rsp_o <= (state == FILL) && last_cap;

      if ((state == IDLE) && ext_req_i) begin
        base_q     <= base_in;
        issue_idx  <= crit_in;
        issued     <= '0;
        captured   <= '0;
        rom_addr_o <= word_addr(base_in, crit_in);
        busy_o     <= 1'b1;
      end

      // After the final issue the address is left on the last word.
      if (issuing) begin
        issued <= issued + 1'b1;
        if (issued < CNT_K'(WORDS-1)) begin
          issue_idx  <= issue_idx + 1'b1;
          rom_addr_o <= word_addr(base_q, issue_idx + 1'b1);
        end
      end

      if (cap_v) begin
        captured <= captured + 1'b1;
        for (int s = 0; s < WORDS; s++) begin
          if (cap_idx == IDX_W'(s)) ext_data_o[32*s +: 32] <= rom_data_i;
        end
      end

      if (state == RESP) begin
        busy_o <= 1'b0;
        if (fill_cnt_o != '1) fill_cnt_o <= fill_cnt_o + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_srv_mem_fill.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_srv_mem_fill
// Purpose  : Self-checking bench for srv_mem_fill. Several instances with
//            different line size / latency / wrap / counter width, each with
//            a ROM returning its own address as data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_srv_mem_fill;

  localparam int N = 5;

  function automatic int p_words(input int g);
    case (g)
      0, 1, 3: return 4;
      2:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic int p_lat(input int g);
    case (g)
      0, 1:    return 0;
      2:       return 2;
      3:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int p_wrap(input int g);
    return (g == 1 || g == 3 || g == 4) ? 1 : 0;
  endfunction

  function automatic int p_cntw(input int g);
    return (g == 3) ? 2 : 16;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         req    [N];
  logic [31:0]  addr   [N];
  logic         rsp_w  [N];
  logic         busy_w [N];
  logic [31:0]  roma_w [N];
  logic [511:0] data_w [N];
  logic [15:0]  cnt_w  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W  = p_words(g);
    localparam int L  = p_lat(g);
    localparam int WR = p_wrap(g);
    localparam int CW = p_cntw(g);

    logic [W*32-1:0] d;
    logic [CW-1:0]   c;
    logic [31:0]     ra;
    logic [31:0]     rd;
    logic            rs;
    logic            bz;

    srv_mem_fill #(.WORDS(W), .ROM_LAT(L), .WRAP_EN(WR), .CNT_W(CW)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ext_addr_i (addr[g]),
      .ext_req_i  (req[g]),
      .ext_rsp_o  (rs),
      .ext_data_o (d),
      .rom_addr_o (ra),
      .rom_data_i (rd),
      .busy_o     (bz),
      .fill_cnt_o (c)
    );

    assign rsp_w[g]  = rs;
    assign busy_w[g] = bz;
    assign roma_w[g] = ra;
    assign data_w[g] = 512'(d);
    assign cnt_w[g]  = 16'(c);

    if (L == 0) begin : g_rom0
      assign rd = ra;
    end else begin : g_romn
      logic [31:0] sr [L];
      always @(posedge clk) begin
        sr[0] <= ra;
        for (int i = 1; i < L; i++) sr[i] <= sr[i-1];
      end
      assign rd = sr[L-1];
    end
  end

  int checks = 0;
  int errors = 0;
  int exp_cnt [N];

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_base(input int id, input logic [31:0] a);
    return a & ~(32'(p_words(id) * 4) - 32'd1);
  endfunction

  function automatic logic [31:0] m_issue(input int id, input logic [31:0] a, input int k);
    int w;
    int crit;
    w    = p_words(id);
    crit = (p_wrap(id) != 0) ? int'(a % 32'(w * 4)) / 4 : 0;
    return m_base(id, a) + 32'(4 * ((crit + k) % w));
  endfunction

  function automatic logic [511:0] m_line(input int id, input logic [31:0] a);
    logic [511:0] line;
    line = '0;
    for (int j = 0; j < p_words(id); j++) line[32*j +: 32] = m_base(id, a) + 32'(4 * j);
    return line;
  endfunction

  function automatic int m_cnt_max(input int id);
    return (1 << p_cntw(id)) - 1;
  endfunction

  // One complete fill. Cycle 0 is the acceptance cycle; pre=1 means the
  // request was already accepted at the coming edge (back-to-back).
  task automatic run_fill(input int id, input logic [31:0] a, input bit pre,
                          input bit drop, input bit keep, input logic [31:0] next_a,
                          output int rsp_cyc, output logic [31:0] first_rom);
    int w, l, last;
    w = p_words(id);
    l = p_lat(id);
    last = w + l + 1;
    rsp_cyc = -1;
    first_rom = '0;
    if (!pre) begin
      @(posedge clk); #1;
      req[id]  = 1'b1;
      addr[id] = a;
      @(negedge clk);
      chk("idle_busy", busy_w[id], 0);
      chk("idle_rsp", rsp_w[id], 0);
    end
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      addr[id] = (keep && c == last) ? next_a : $urandom();
      if (drop && c == 2) req[id] = 1'b0;
      if (!keep && c == last) req[id] = 1'b0;
      @(negedge clk);
      if (c == 1) first_rom = roma_w[id];
      if (rsp_w[id] && rsp_cyc < 0) rsp_cyc = c;
      chk("fill_busy", busy_w[id], 1);
      chk("fill_rsp", rsp_w[id], 512'(c == last));
      chk("fill_rom_addr", roma_w[id], m_issue(id, a, (c <= w) ? c - 1 : w - 1));
      if (c == last) begin
        chk("line_data", data_w[id], m_line(id, a));
        chk("cnt_in_resp", cnt_w[id], 512'(exp_cnt[id]));
      end
    end
    if (exp_cnt[id] < m_cnt_max(id)) exp_cnt[id]++;
    @(negedge clk);
    chk("post_busy", busy_w[id], 0);
    chk("post_rsp", rsp_w[id], 0);
    chk("fill_cnt", cnt_w[id], 512'(exp_cnt[id]));
  endtask

  task automatic chk_reset_state(input int id);
    chk("rst_busy", busy_w[id], 0);
    chk("rst_rsp", rsp_w[id], 0);
    chk("rst_rom_addr", roma_w[id], 0);
    chk("rst_data", data_w[id], 0);
    chk("rst_cnt", cnt_w[id], 0);
  endtask

  typedef struct {
    int           id;
    logic [31:0]  addr;
    bit           drop;
    int           exp_rsp;
    logic [31:0]  exp_first;
    logic [255:0] exp_line;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rc;
    int seen;
    int id;
    logic [31:0] fr;
    logic [31:0] a;
    int sat_exp [5];

    tbl[0] = '{0, 32'h24,       1'b0, 5,  32'h20,
               256'h0000002C_00000028_00000024_00000020};
    tbl[1] = '{1, 32'h28,       1'b0, 5,  32'h28,
               256'h0000002C_00000028_00000024_00000020};
    tbl[2] = '{2, 32'h104,      1'b0, 11, 32'h100,
               256'h0000011C_00000118_00000114_00000110_0000010C_00000108_00000104_00000100};
    tbl[3] = '{4, 32'h12345677, 1'b0, 5,  32'h12345674, 256'h12345674};
    tbl[4] = '{3, 32'h3C,       1'b0, 6,  32'h3C,
               256'h0000003C_00000038_00000034_00000030};
    tbl[5] = '{0, 32'h8,        1'b1, 5,  32'h0,
               256'h0000000C_00000008_00000004_00000000};
    sat_exp = '{1, 2, 3, 3, 3};

    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      req[i]     = 1'b0;
      addr[i]    = '0;
      exp_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) chk_reset_state(i);
    rst_n = 1'b1;

    // Directed vectors
    for (int t = 0; t < 6; t++) begin
      run_fill(tbl[t].id, tbl[t].addr, 1'b0, tbl[t].drop, 1'b0, '0, rc, fr);
      chk("tbl_rsp_cycle", 512'(rc), 512'(tbl[t].exp_rsp));
      chk("tbl_first_rom", fr, tbl[t].exp_first);
      chk("tbl_line", data_w[tbl[t].id], 512'(tbl[t].exp_line));
    end

    // Back-to-back with request held high: second acceptance in the first
    // IDLE cycle, response five cycles later.
    run_fill(0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h40, rc, fr);
    chk("b2b_rsp1", 512'(rc), 512'(5));
    run_fill(0, 32'h40, 1'b1, 1'b0, 1'b0, '0, rc, fr);
    chk("b2b_rsp2", 512'(rc), 512'(5));
    chk("b2b_first_rom", fr, 32'h40);

    // Reset in cycle 3 of a fill
    @(posedge clk); #1;
    req[2]  = 1'b1;
    addr[2] = 32'h200;
    repeat (3) @(posedge clk);
    #2;
    rst_n  = 1'b0;
    req[2] = 1'b0;
    #1;
    chk_reset_state(2);
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_w[2]) seen++;
    end
    chk("no_rsp_after_reset", 512'(seen), 0);
    chk("data_cleared", data_w[2], 0);
    run_fill(2, 32'h300, 1'b0, 1'b0, 1'b0, '0, rc, fr);
    chk("after_reset_rsp", 512'(rc), 512'(11));

    // Counter saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      run_fill(3, $urandom(), 1'b0, 1'b0, 1'b0, '0, rc, fr);
      chk("sat_cnt", cnt_w[3], 512'(sat_exp[i]));
    end

    // Randomized fills against the model
    repeat (25) begin
      id = $urandom_range(0, N - 1);
      a  = $urandom();
      run_fill(id, a, 1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, rc, fr);
      chk("rand_rsp_cycle", 512'(rc), 512'(p_words(id) + p_lat(id) + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
